morse_receiver: RTL and testbench

Decodes serial Morse on/off bit streams back into 3-bit letter indices 0–7. It is the receive-side counterpart of the letter transmitter and consumes the same DotDash/NewBit strobe pair, one bit per strobe. It frames each 12-bit code, matches it against the shared 8-letter table, and reports a valid letter or a frame error. A watchdog aborts frames whose strobes stop arriving.

---
 rtl/morse_receiver.sv | 93 +++++++++
 tb/tb_morse_receiver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/morse_receiver.sv
// morse_receiver: frames strobed Morse bits into 12-bit codes and decodes them to letter indices,
// flagging unmatched codes and stalled frames.
module morse_receiver #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic        ClockIn,
  input  logic        Reset,
  input  logic        DotDashIn,
  input  logic        NewBitIn,
  output logic [2:0]  LetterOut,
  output logic        LetterValid,
  output logic        FrameError,
  output logic [11:0] PatternOut,
  output logic        Busy
);
  localparam int WDW = $clog2(CLOCK_FREQUENCY + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(CLOCK_FREQUENCY);
  localparam logic [11:0] CODES [8] = '{12'hB80, 12'hEA8, 12'hEBA, 12'hEA0,
                                        12'h800, 12'hAE8, 12'hEE8, 12'hAA0};
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t          state_q;
  logic [11:0]     shift_q;
  logic [3:0]      bitcount_q;
  logic [WDW-1:0]  wd_q;
  logic [2:0]      letter_q;
  logic            valid_q;
  logic            err_q;
  logic [11:0]     pattern_q;
  logic [11:0]     word_d;
  logic            hit_d;
  logic [2:0]      idx_d;
  assign word_d = {shift_q[10:0], DotDashIn};
  always_comb begin
    hit_d = 1'b0;
    idx_d = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (word_d == CODES[i]) begin
        hit_d = 1'b1;
        idx_d = 3'(i);
      end
    end
  end
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitcount_q <= '0;
      wd_q       <= '0;
      letter_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      pattern_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE) begin
        wd_q <= '0;
        if (NewBitIn && DotDashIn) begin
          shift_q    <= 12'd1;
          bitcount_q <= 4'd1;
          state_q    <= COLLECT;
        end
      end else if (NewBitIn) begin
        // a strobe always beats a same-cycle watchdog expiry
        wd_q       <= '0;
        shift_q    <= word_d;
        bitcount_q <= bitcount_q + 4'd1;
        if (bitcount_q == 4'd11) begin
          state_q   <= IDLE;
          pattern_q <= word_d;
          if (hit_d) begin
            letter_q <= idx_d;
            valid_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (wd_q == WD_LIMIT) begin
        wd_q      <= '0;
        err_q     <= 1'b1;
        pattern_q <= shift_q;
        state_q   <= IDLE;
      end else begin
        wd_q <= wd_q + WDW'(1);
      end
    end
  end
  assign LetterOut   = letter_q;
  assign LetterValid = valid_q;
  assign FrameError  = err_q;
  assign PatternOut  = pattern_q;
  assign Busy        = state_q == COLLECT;
endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: random and directed Morse streams checked against a timestamped event model.
module tb_morse_receiver;
  logic        ClockIn = 1'b0;
  logic        Reset = 1'b1;
  logic        DotDashIn = 1'b0;
  logic        NewBitIn = 1'b0;
  logic [2:0]  LetterOut;
  logic        LetterValid;
  logic        FrameError;
  logic [11:0] PatternOut;
  logic        Busy;
  localparam int LIMIT = 500;
  always #5 ClockIn = ~ClockIn;
  morse_receiver #(.CLOCK_FREQUENCY(LIMIT)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .DotDashIn(DotDashIn), .NewBitIn(NewBitIn),
    .LetterOut(LetterOut), .LetterValid(LetterValid), .FrameError(FrameError),
    .PatternOut(PatternOut), .Busy(Busy)
  );
  typedef struct {int at; int err; int letter; int pattern;} ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t oe;
  logic [11:0] codes [8] = '{12'hB80, 12'hEA8, 12'hEBA, 12'hEA0,
                             12'h800, 12'hAE8, 12'hEE8, 12'hAA0};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m_busy = 0, m_cnt = 0, m_last = 0, m_letter = 0;
  logic [11:0] m_shift = '0;
  always @(posedge ClockIn) cyc <= cyc + 1;
  task automatic chk(string tag, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic void push(int at, int err, int letter, int pattern);
    ev_t e;
    e.at = at; e.err = err; e.letter = letter; e.pattern = pattern;
    exp_q.push_back(e);
  endfunction
  // A frame left without a strobe for LIMIT+1 edges errors on that edge
  function automatic void model_timeout(int p);
    if (m_busy != 0 && p - m_last > LIMIT + 1) begin
      push(m_last + LIMIT + 1, 1, m_letter, int'(m_shift));
      m_busy = 0;
    end
  endfunction
  function automatic void model_strobe(int p, logic dd);
    int idx;
    model_timeout(p);
    if (m_busy == 0) begin
      if (dd) begin
        m_busy = 1; m_shift = 12'd1; m_cnt = 1; m_last = p;
      end
    end else begin
      m_shift = {m_shift[10:0], dd};
      m_cnt++;
      m_last = p;
      if (m_cnt == 12) begin
        idx = -1;
        for (int i = 0; i < 8; i++) if (codes[i] == m_shift) idx = i;
        if (idx >= 0) begin
          m_letter = idx;
          push(p, 0, idx, int'(m_shift));
        end else push(p, 1, m_letter, int'(m_shift));
        m_busy = 0;
      end
    end
  endfunction
  always @(negedge ClockIn) begin
    if (LetterValid || FrameError) begin
      oe.at = cyc; oe.err = int'(FrameError); oe.letter = int'(LetterOut); oe.pattern = int'(PatternOut);
      obs_q.push_back(oe);
    end
    if (LetterValid && FrameError) chk("exclusive", 1, 0);
  end
  task automatic step(logic nb, logic dd);
    if (nb) model_strobe(cyc + 1, dd);
    NewBitIn = nb;
    DotDashIn = dd;
    @(negedge ClockIn);
    NewBitIn = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) step(1'b0, 1'($urandom));
  endtask
  task automatic send(logic [11:0] code, int n, int gmin, int gmax, int longp);
    for (int i = 0; i < n; i++) begin
      step(1'b1, code[11-i]);
      if (longp != 0 && $urandom_range(15, 0) == 0) idle($urandom_range(503, 499));
      else idle($urandom_range(gmax, gmin));
    end
  endtask
  task automatic do_reset();
    model_timeout(cyc + 1);
    m_busy = 0;
    m_letter = 0;
    Reset = 1'b1;
    NewBitIn = 1'b1;
    DotDashIn = 1'b1;
    @(negedge ClockIn);
    Reset = 1'b0;
    NewBitIn = 1'b0;
    chk("rst_letter", int'(LetterOut), 0);
    chk("rst_valid", int'(LetterValid), 0);
    chk("rst_err", int'(FrameError), 0);
    chk("rst_pattern", int'(PatternOut), 0);
    chk("rst_busy", int'(Busy), 0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge ClockIn);
    Reset = 1'b0;
    chk("init_letter", int'(LetterOut), 0);
    chk("init_pattern", int'(PatternOut), 0);
    chk("init_busy", int'(Busy), 0);
    send(codes[0], 12, 250, 250, 0);
    chk("single_letter", int'(LetterOut), 0);
    chk("single_pattern", int'(PatternOut), 'hB80);
    for (int l = 0; l < 8; l++) begin
      repeat (3) step(1'b1, 1'b0);
      idle($urandom_range(2, 0));
      send(codes[l], 12, 0, 3, 0);
    end
    chk("b2b_last", int'(LetterOut), 7);
    send(12'hFFF, 12, 0, 1, 0);
    idle(2);
    chk("bad_pattern", int'(PatternOut), 'hFFF);
    chk("bad_letter_kept", int'(LetterOut), 7);
    chk("bad_busy", int'(Busy), 0);
    send(codes[2], 5, 0, 0, 0);
    chk("wd_busy_mid", int'(Busy), 1);
    idle(600);
    chk("wd_pattern", int'(PatternOut), 'h01D);
    chk("wd_busy", int'(Busy), 0);
    send(codes[1], 7, 0, 1, 0);
    chk("midrst_busy", int'(Busy), 1);
    do_reset();
    send(codes[4], 12, 0, 1, 0);
    idle(2);
    chk("after_rst_letter", int'(LetterOut), 4);
    send(codes[6], 12, 0, 0, 0);
    send(codes[5], 12, 0, 2, 0);
    chk("collision_letter", int'(LetterOut), 5);
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(2, 0)) step(1'b1, 1'b0);
      n = $urandom_range(9, 0);
      send(n < 8 ? codes[n] : {1'b1, 11'($urandom)}, 12, 0, 3, 1);
      if ($urandom_range(19, 0) == 0) do_reset();
    end
    idle(600);
    model_timeout(cyc + 1);
    chk("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk("ev_cycle", obs_q[i].at, exp_q[i].at);
      chk("ev_error", obs_q[i].err, exp_q[i].err);
      chk("ev_letter", obs_q[i].letter, exp_q[i].letter);
      chk("ev_pattern", obs_q[i].pattern, exp_q[i].pattern);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
